// File: rtl/op_stim_signature.sv
// rtl/op_stim_signature.sv - LFSR operand generator and 16-bit MISR compactor for the four-operand operator block
module op_stim_signature #(
  parameter int          NUM_VECTORS = 16,
  parameter int          SETTLE      = 2,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  input  logic [3:0]  Arithmetic,
  input  logic [3:0]  Shift,
  input  logic [3:0]  Relational,
  input  logic [3:0]  Equality,
  input  logic [3:0]  Bitwise,
  input  logic [3:0]  Reduction,
  input  logic [3:0]  Logical,
  input  logic [3:0]  Concatenation,
  input  logic [3:0]  Conditional,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vec_count,
  output logic [15:0] signature
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] LOAD_VAL   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [3:0]  SETTLE_VAL = 4'(SETTLE);
  localparam logic [7:0]  NUM_VAL    = 8'(NUM_VECTORS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  cnt_vec_q, cnt_vec_d;
  logic [3:0]  settle_q, settle_d;

  logic [35:0] res;
  logic [15:0] fold;
  logic        sig_fb;
  logic        lfsr_fb;

  assign res     = {Arithmetic, Shift, Relational, Equality, Bitwise,
                    Reduction, Logical, Concatenation, Conditional};
  assign fold    = res[35:20] ^ res[19:4] ^ {res[3:0], 12'h000};
  assign sig_fb  = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 16'h0000;
      sig_q     <= 16'h0000;
      cnt_vec_q <= 8'h00;
      settle_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      sig_q     <= sig_d;
      cnt_vec_q <= cnt_vec_d;
      settle_q  <= settle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    sig_d     = sig_q;
    cnt_vec_d = cnt_vec_q;
    settle_d  = settle_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d    = LOAD_VAL;
          sig_d     = 16'h0000;
          cnt_vec_d = 8'h00;
          settle_d  = SETTLE_VAL;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        sig_d     = {sig_q[14:0], sig_fb} ^ fold;
        cnt_vec_d = cnt_vec_q + 8'd1;
        // The last vector stays on the operand buses after the run ends.
        if (cnt_vec_q + 8'd1 == NUM_VAL) begin
          state_d = S_DONE;
        end else begin
          lfsr_d   = {lfsr_q[14:0], lfsr_fb};
          settle_d = SETTLE_VAL;
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {A, B, C, D} = lfsr_q;
  assign busy         = (state_q == S_WAIT) || (state_q == S_CAPTURE);
  assign done         = (state_q == S_DONE);
  assign vec_count    = cnt_vec_q;
  assign signature    = sig_q;

endmodule
